// File: rtl/cim_pkg.sv
// Shared definitions for CIM layer controllers.
//   t_layer_ctrl_state : sequencer states of a fully-connected layer controller
//   ceil_div           : ceiled division, used for tile counts
//   bits_for           : index width for n items (never below 1)
package cim_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HANDOFF,
        S_FUNC_START
    } t_layer_ctrl_state;

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

    function automatic int unsigned bits_for(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cim_done_collector.sv
// Collects per-tile done pulses into a sticky mask.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : load the mask with the current done vector (starts a new collection)
//   acc      : OR the current done vector into the mask
//   done     : per-tile done pulses
//   mask     : registered collected mask
//   all_set  : every tile has reported, including a done arriving this cycle
module cim_done_collector #(
    parameter int unsigned width = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             acc,
    input  logic [width-1:0] done,
    output logic [width-1:0] mask,
    output logic             all_set
);

    logic [width-1:0] mask_q;
    logic [width-1:0] mask_d;

    always_comb begin
        mask_d = mask_q;
        if (clear) begin
            mask_d = done;
        end else if (acc) begin
            mask_d = mask_q | done;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign mask    = mask_q;
    assign all_set = &(mask_q | done);

endmodule

// File: rtl/fc_layer_ctrl.sv
// Per-layer sequencer for one fully-connected CIM layer.
// Issues one crossbar op per input bit-plane (LSB first), waits for every vertical tile
// to report done, then hands off to the func unit.
//   clk, rst     : clock, asynchronous active-high reset
//   i_start      : upstream pulse, input vector ready
//   o_busy       : layer busy (state != S_IDLE)
//   o_cim_start  : pulse, all tiles start an op on plane o_bit_idx
//   o_bit_idx    : current bit-plane index
//   i_cim_done   : per-tile done pulses
//   o_cim_busy   : crossbar ops outstanding
//   i_func_busy  : func unit busy
//   o_func_start : pulse, start func unit readout
//   o_inf_count  : completed inferences (wrapping)
//   o_err        : sticky, done pulse seen with no op outstanding
module fc_layer_ctrl
    import cim_pkg::*;
#(
    parameter int unsigned input_size    = 257,
    parameter int unsigned xbar_size     = 256,
    parameter int unsigned datatype_size = 8,
    parameter int unsigned v_cim_tiles   = ceil_div(input_size, xbar_size),
    parameter int unsigned count_width   = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_start,
    output logic                             o_busy,
    output logic                             o_cim_start,
    output logic [$clog2(datatype_size)-1:0] o_bit_idx,
    input  logic [v_cim_tiles-1:0]           i_cim_done,
    output logic                             o_cim_busy,
    input  logic                             i_func_busy,
    output logic                             o_func_start,
    output logic [count_width-1:0]           o_inf_count,
    output logic                             o_err
);

    localparam int unsigned bw = $clog2(datatype_size);
    localparam logic [bw-1:0] last_idx = bw'(datatype_size - 1);

    t_layer_ctrl_state state_q, state_d;
    logic [bw-1:0]          bit_idx_q, bit_idx_d;
    logic [count_width-1:0] count_q, count_d;
    logic                   err_q, err_d;

    logic                   all_done;
    logic [v_cim_tiles-1:0] done_mask;

    cim_done_collector #(
        .width(v_cim_tiles)
    ) u_done_collector (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q == S_ISSUE),
        .acc    (state_q == S_WAIT),
        .done   (i_cim_done),
        .mask   (done_mask),
        .all_set(all_done)
    );

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        count_d   = count_q;
        err_d     = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d   = S_ISSUE;
                    bit_idx_d = '0;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // all_done already includes this cycle's pulses
                if (all_done) begin
                    if (bit_idx_q == last_idx) begin
                        state_d = S_HANDOFF;
                    end else begin
                        bit_idx_d = bit_idx_q + bw'(1);
                        state_d   = S_ISSUE;
                    end
                end
            end
            S_HANDOFF: begin
                if (!i_func_busy) begin
                    state_d = S_FUNC_START;
                end
            end
            S_FUNC_START: begin
                state_d = S_IDLE;
                count_d = count_q + count_width'(1);
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A done pulse is only legitimate while an op is outstanding
        if ((state_q != S_ISSUE) && (state_q != S_WAIT) && (|i_cim_done)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_idx_q <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

    assign o_cim_start  = (state_q == S_ISSUE);
    assign o_cim_busy   = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign o_busy       = (state_q != S_IDLE);
    assign o_func_start = (state_q == S_FUNC_START);
    assign o_bit_idx    = bit_idx_q;
    assign o_inf_count  = count_q;
    assign o_err        = err_q;

endmodule
